wb_intercon_mp: RTL and testbench
=================================

# wb_intercon_mp

Parametrised multi-master successor to the single-master `WB_intercon`. It sits between N bus masters (the multi-cycle CPU, a future DMA or debug port) and M flattened Wishbone-style slaves (RAM, Disk, VRAM, Keyboard, Counter, …). It arbitrates masters round-robin, decodes the slave from upper address bits, and registers the request and response. Unmapped accesses terminate with an error, and stalled slaves can optionally be timed out.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of masters, 1..8.
- `N_SLAVES`, default 16: number of slaves, 1..16.
- `DW`, default 32: data width.
- `AW`, default 32: address width.
- `SEL_HI`, default 31: high bit of the slave-select field in ADDR.
- `SEL_LO`, default 28: low bit of the slave-select field in ADDR.
- `TIMEOUT`, default 255: BUSY cycles before error termination, 1..65535; used only with `WB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single bus clock. Decided: one clock; reset is asynchronous and active-low.
- `RSTN` in 1: asynchronous, active-low reset.
- `master_STB` in N_MASTERS: request strobe, one bit per master.
- `master_WE` in N_MASTERS: 1 = write.
- `master_ADDR` in N_MASTERS*AW: byte address; master i occupies slice [i*AW +: AW].
- `master_DAT_I` in N_MASTERS*DW: write data from masters.
- `master_DAT_O` out N_MASTERS*DW: read data to masters; every slice carries the same register.
- `master_ACK` out N_MASTERS: one-cycle completion pulse.
- `master_ERR` out N_MASTERS: one-cycle error pulse.
- `slave_STB` out N_SLAVES: one-hot strobe.
- `slave_WE` out 1: shared write enable.
- `slave_ADDR` out AW: shared address.
- `slave_DAT_O` out DW: shared write data.
- `slave_DAT_I` in N_SLAVES*DW: read data; slave j occupies slice [j*DW +: DW].
- `slave_ACK` in N_SLAVES: per-slave acknowledge; combinational or registered.

## Operation
The block is a three-state FSM: IDLE, BUSY, DONE.

IDLE:
- If any `master_STB` is set, grant the first requester after `last_grant`, searching upward and wrapping.
- On the grant edge, register `gnt`, `slave_ADDR`, `slave_WE` and `slave_DAT_O` from the granted master.
- Compute `sel = ADDR[SEL_HI:SEL_LO]`.
- If `sel < N_SLAVES`, go to BUSY.
- Otherwise go to DONE with `err=1` (decode error). No `slave_STB` is ever asserted for this access.
- `last_grant` updates on every grant.

BUSY:
- `slave_STB[sel]=1`; all other STB bits are 0.
- If `slave_ACK[sel]=1`, capture `slave_DAT_I[sel]` into `rdata` and go to DONE with `err=0`.
- If the granted master drops STB before ACK (abort), go to IDLE with no ACK and `rdata` unchanged.
- ACK and abort in the same cycle: ACK wins.
- Only `slave_ACK[sel]` is observed. ACKs from other slaves are ignored.

DONE:
- Assert `master_ACK[gnt]` (or `master_ERR[gnt]` if `err`) for exactly one cycle, then go to IDLE.
- `slave_STB` is all zero.
- The master must drop STB on the edge where it samples ACK/ERR. If STB is still high in IDLE, that is a new transaction.

Arbitration and data:
- After reset, `last_grant = N_MASTERS-1`, so master 0 has the highest priority first.
- With N_MASTERS=1, the arbiter degenerates to always granting master 0.
- Decode-error and timeout terminations return `rdata = 0`.
- Writes leave `rdata` unchanged.

Reset (async, any state):
- FSM returns to IDLE.
- `slave_STB`, `master_ACK`, `master_ERR`, `slave_WE`, `slave_ADDR`, `slave_DAT_O`, `rdata` and the timeout counter are all cleared to 0.
- An in-flight transaction is dropped silently.

## Timing
- Master STB raised in cycle 0 → `slave_STB` high in cycle 1.
- Slave ACK in cycle k (k≥1) → `master_ACK` high in cycle k+1.
- With a zero-wait slave (ACK in cycle 1), ACK reaches the master in cycle 2. Minimum transaction is 3 cycles including the DONE→IDLE return.
- Decode error: `master_ERR` high in cycle 2.
- Back-to-back: one idle cycle between a DONE and the next grant.
- All outputs are registered except `master_DAT_O`, which is a wire fan-out of `rdata`.

## Configuration
`WB_TIMEOUT_EN`:
- Defined: a 16-bit counter clears on entering BUSY and increments each BUSY cycle without ACK. When it reaches `TIMEOUT`, the FSM goes to DONE with `err=1` and `rdata=0`, giving ERR in cycle TIMEOUT+2.
- Undefined: there is no counter and BUSY waits indefinitely for ACK or abort.

## Test plan
- Master 0 reads addr 0x0000_0010, slave 0 ACKs in cycle 1 with 0x1234_5678 → `slave_STB`=0x0001 in cycle 1, `master_ACK[0]` in cycle 2, `master_DAT_O`=0x1234_5678.
- Masters 0 and 1 both hold STB continuously to slave 2 (addr 0x2000_0000) → grants alternate 0,1,0,1 and each gets ACK.
- N_SLAVES=5, write to 0xF000_0000 → no `slave_STB` bit ever set, `master_ERR` in cycle 2, `master_ACK` stays 0.
- `WB_TIMEOUT_EN` defined, TIMEOUT=8, slave 4 never ACKs → `master_ERR` in cycle 10, `rdata`=0. Without the macro, `slave_STB[4]` remains high after 1000 cycles.
- Master drops STB in cycle 3 of a BUSY access → `slave_STB` 0 next cycle, no ACK/ERR, FSM in IDLE.
- `RSTN` low during BUSY → all outputs 0 immediately; after release, the first grant goes to master 0.

Source files
------------

// File: rtl/wb_intercon_mp.sv
// wb_intercon_mp: multi-master Wishbone-style interconnect.
//
// Arbitrates N_MASTERS requesters round-robin. The granted request is
// registered onto the shared slave bus. The target slave is decoded from
// ADDR[SEL_HI:SEL_LO], and the read data and completion are registered on
// the way back. Unmapped selects end with a decode error.
//
// Optional build macro: WB_TIMEOUT_EN. When it is defined, a stalled slave
// is abandoned after TIMEOUT busy cycles and the access ends in an error.
//
// Ports:
//   clk, RSTN       bus clock, asynchronous active-low reset
//   master_STB/WE   per-master request strobe and write flag
//   master_ADDR     per-master byte address, slice [i*AW +: AW]
//   master_DAT_I    per-master write data, slice [i*DW +: DW]
//   master_DAT_O    read data; every slice carries the same register
//   master_ACK/ERR  one-cycle completion / error pulse to the granted master
//   slave_STB       one-hot slave strobe
//   slave_WE/ADDR   shared write flag and address
//   slave_DAT_O     shared write data
//   slave_DAT_I     per-slave read data, slice [j*DW +: DW]
//   slave_ACK       per-slave acknowledge
//
// state | meaning
// IDLE  | pick the next requester; decode its slave select
// BUSY  | strobe the selected slave until ACK, abort or timeout
// DONE  | pulse ACK/ERR to the granted master for one cycle
module wb_intercon_mp #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 16,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int SEL_HI    = 31,
    parameter int SEL_LO    = 28,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    RSTN,
    input  logic [N_MASTERS-1:0]    master_STB,
    input  logic [N_MASTERS-1:0]    master_WE,
    input  logic [N_MASTERS*AW-1:0] master_ADDR,
    input  logic [N_MASTERS*DW-1:0] master_DAT_I,
    output logic [N_MASTERS*DW-1:0] master_DAT_O,
    output logic [N_MASTERS-1:0]    master_ACK,
    output logic [N_MASTERS-1:0]    master_ERR,
    output logic [N_SLAVES-1:0]     slave_STB,
    output logic                    slave_WE,
    output logic [AW-1:0]           slave_ADDR,
    output logic [DW-1:0]           slave_DAT_O,
    input  logic [N_SLAVES*DW-1:0]  slave_DAT_I,
    input  logic [N_SLAVES-1:0]     slave_ACK
);
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = SEL_HI - SEL_LO + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        gnt, gnt_nxt;
    logic [GW-1:0]        last_grant, last_grant_nxt;
    logic [SW-1:0]        sel, sel_nxt;
    logic                 err_pend, err_pend_nxt;
    logic [DW-1:0]        rdata, rdata_nxt;
    logic [N_SLAVES-1:0]  stb_nxt;
    logic [N_MASTERS-1:0] ack_nxt, err_nxt;
    logic                 we_nxt;
    logic [AW-1:0]        addr_nxt;
    logic [DW-1:0]        dat_nxt;

    logic                 req_found;
    logic [GW-1:0]        req_idx;
    int                   cand;
    logic [AW-1:0]        addr_req;
    logic [SW-1:0]        sel_req;
    logic                 mapped;
    logic                 sel_ack;
    logic [DW-1:0]        sel_dat;
    logic                 tmo;

`ifdef WB_TIMEOUT_EN
    logic [15:0]          tcnt, tcnt_nxt;
    assign tmo = (tcnt == 16'(TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    assign master_DAT_O = {N_MASTERS{rdata}};

    // Round-robin: first requester strictly after last_grant, wrapping.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = (int'(last_grant) + i) % N_MASTERS;
            if (!req_found && master_STB[cand]) begin
                req_found = 1'b1;
                req_idx   = GW'(cand);
            end
        end
    end

    assign addr_req = master_ADDR[req_idx*AW +: AW];
    assign sel_req  = addr_req[SEL_HI:SEL_LO];
    assign mapped   = (int'(sel_req) < N_SLAVES);

    // Only the selected slave's ACK and data are ever looked at.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (int'(sel) == j) begin
                sel_ack = slave_ACK[j];
                sel_dat = slave_DAT_I[j*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        last_grant_nxt = last_grant;
        sel_nxt        = sel;
        err_pend_nxt   = 1'b0;
        rdata_nxt      = rdata;
        stb_nxt        = '0;
        ack_nxt        = '0;
        err_nxt        = '0;
        we_nxt         = slave_WE;
        addr_nxt       = slave_ADDR;
        dat_nxt        = slave_DAT_O;
`ifdef WB_TIMEOUT_EN
        tcnt_nxt       = tcnt;
`endif
        case (state)
            IDLE: begin
                if (req_found) begin
                    gnt_nxt        = req_idx;
                    last_grant_nxt = req_idx;
                    addr_nxt       = addr_req;
                    we_nxt         = master_WE[req_idx];
                    dat_nxt        = master_DAT_I[req_idx*DW +: DW];
                    sel_nxt        = sel_req;
`ifdef WB_TIMEOUT_EN
                    tcnt_nxt       = '0;
`endif
                    if (mapped) begin
                        state_nxt = BUSY;
                        for (int j = 0; j < N_SLAVES; j++)
                            stb_nxt[j] = (int'(sel_req) == j);
                    end else begin
                        // Decode errors spend one extra DONE cycle so the
                        // ERR pulse lands at the same point an ACK from a
                        // zero-wait slave would.
                        state_nxt    = DONE;
                        err_pend_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (sel_ack) begin
                    state_nxt    = DONE;
                    ack_nxt[gnt] = 1'b1;
                    if (!slave_WE)
                        rdata_nxt = sel_dat;
                end else if (!master_STB[gnt]) begin
                    state_nxt = IDLE;
                end else if (tmo) begin
                    state_nxt    = DONE;
                    err_nxt[gnt] = 1'b1;
                    rdata_nxt    = '0;
                end else begin
                    stb_nxt = slave_STB;
`ifdef WB_TIMEOUT_EN
                    tcnt_nxt = tcnt + 16'd1;
`endif
                end
            end
            DONE: begin
                if (err_pend) begin
                    err_nxt[gnt] = 1'b1;
                    rdata_nxt    = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            gnt         <= '0;
            last_grant  <= GW'(N_MASTERS - 1);
            sel         <= '0;
            err_pend    <= 1'b0;
            rdata       <= '0;
            slave_STB   <= '0;
            master_ACK  <= '0;
            master_ERR  <= '0;
            slave_WE    <= 1'b0;
            slave_ADDR  <= '0;
            slave_DAT_O <= '0;
`ifdef WB_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last_grant  <= last_grant_nxt;
            sel         <= sel_nxt;
            err_pend    <= err_pend_nxt;
            rdata       <= rdata_nxt;
            slave_STB   <= stb_nxt;
            master_ACK  <= ack_nxt;
            master_ERR  <= err_nxt;
            slave_WE    <= we_nxt;
            slave_ADDR  <= addr_nxt;
            slave_DAT_O <= dat_nxt;
`ifdef WB_TIMEOUT_EN
            tcnt        <= tcnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_wb_intercon_mp.sv
// Bench for wb_intercon_mp: two masters, five slaves, TIMEOUT=8.
module tb_wb_intercon_mp;
    localparam int NM  = 2;
    localparam int NS  = 5;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_stb, m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdat;
    logic [NM*DW-1:0] m_rdat;
    logic [NM-1:0]    m_ack, m_err;
    logic [NS-1:0]    s_stb;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdat;
    logic [NS*DW-1:0] s_rdat;
    logic [NS-1:0]    s_ack, ack_model, spur_ack;

    assign s_ack = ack_model | spur_ack;

    wb_intercon_mp #(
        .N_MASTERS(NM), .N_SLAVES(NS), .DW(DW), .AW(AW),
        .SEL_HI(31), .SEL_LO(28), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .RSTN(rstn),
        .master_STB(m_stb), .master_WE(m_we), .master_ADDR(m_addr),
        .master_DAT_I(m_wdat), .master_DAT_O(m_rdat),
        .master_ACK(m_ack), .master_ERR(m_err),
        .slave_STB(s_stb), .slave_WE(s_we), .slave_ADDR(s_addr),
        .slave_DAT_O(s_wdat), .slave_DAT_I(s_rdat), .slave_ACK(s_ack)
    );

    // Slave model: ACK after ws[j] wait cycles of STB, never if stalled.
    int          ws[NS];
    logic        stall[NS];
    int          scnt[NS];
    logic [31:0] acc_addr, acc_dat;
    logic        acc_we;

    always @(negedge clk) begin
        for (int j = 0; j < NS; j++) begin
            if (s_stb[j]) begin
                scnt[j] = scnt[j] + 1;
                ack_model[j] = !stall[j] && (scnt[j] > ws[j]);
            end else begin
                scnt[j] = 0;
                ack_model[j] = 1'b0;
            end
            if (ack_model[j]) begin
                acc_addr = s_addr;
                acc_we   = s_we;
                acc_dat  = s_wdat;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        m_stb[m]          = 1'b1;
        m_we[m]           = we;
        m_addr[m*AW +: AW] = a;
        m_wdat[m*DW +: DW] = d;
    endtask

    // Raise a request in the current cycle (cycle 0) and wait for its response.
    task automatic run_txn(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic got_ack, output logic got_err, output int lat);
        set_req(m, we, a, d);
        lat = 0;
        got_ack = 1'b0;
        got_err = 1'b0;
        while (lat < 100) begin
            tick();
            lat++;
            if (m_ack[m] || m_err[m]) begin
                got_ack = m_ack[m];
                got_err = m_err[m];
                break;
            end
        end
        m_stb[m] = 1'b0;
    endtask

    typedef struct {
        int          mst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        int          wst;
        logic [31:0] sdat;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ga, ge, any_resp;
        int          lat, sel, n, first;
        int          order[6], when[6];
        int          prev;
        logic [NM-1:0] act, just, r_we;
        logic [31:0] r_addr[NM], r_wd[NM];
        int          r_wait[NM], r_oth[NM];
        logic [31:0] exp_rd;
        logic        exp_e;

        vt[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678, 1'b0, 2, 32'h1234_5678};
        vt[1] = '{1, 1'b0, 32'h1000_0004, 32'h0,         2, 32'hCAFE_F00D, 1'b0, 4, 32'hCAFE_F00D};
        vt[2] = '{0, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 1, 32'h1111_1111, 1'b0, 3, 32'hCAFE_F00D};
        vt[3] = '{1, 1'b1, 32'hF000_0000, 32'h5555_AAAA, 0, 32'h0,         1'b1, 2, 32'h0};
        vt[4] = '{0, 1'b0, 32'h3000_0008, 32'h0,         3, 32'hA5A5_A5A5, 1'b0, 5, 32'hA5A5_A5A5};
        vt[5] = '{1, 1'b0, 32'h5000_0000, 32'h0,         0, 32'h0,         1'b1, 2, 32'h0};
        vt[6] = '{0, 1'b0, 32'h4000_0000, 32'h0,         0, 32'h0BAD_CAFE, 1'b0, 2, 32'h0BAD_CAFE};
        vt[7] = '{1, 1'b1, 32'h4FFF_FFFC, 32'h0102_0304, 0, 32'h0BAD_CAFE, 1'b0, 2, 32'h0BAD_CAFE};

        rstn = 1'b0;
        m_stb = '0; m_we = '0; m_addr = '0; m_wdat = '0;
        s_rdat = '0; spur_ack = '0;
        for (int j = 0; j < NS; j++) begin ws[j] = 0; stall[j] = 1'b0; end

        // Reset values
        repeat (3) tick();
        chk("rst slave_STB", s_stb, 0);
        chk("rst master_ACK", m_ack, 0);
        chk("rst master_ERR", m_err, 0);
        chk("rst slave_ADDR", s_addr, 0);
        chk("rst master_DAT_O", m_rdat, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post-rst slave_STB", s_stb, 0);
        chk("post-rst slave_WE", s_we, 0);
        chk("post-rst slave_DAT_O", s_wdat, 0);

        // Zero-wait read, cycle by cycle
        ws[0] = 0;
        s_rdat[0 +: 32] = 32'h1234_5678;
        set_req(0, 1'b0, 32'h0000_0010, 32'h0);
        tick();
        chk("zw c1 slave_STB", s_stb, 5'b00001);
        chk("zw c1 slave_ADDR", s_addr, 32'h0000_0010);
        chk("zw c1 slave_WE", s_we, 0);
        chk("zw c1 master_ACK", m_ack, 0);
        tick();
        chk("zw c2 master_ACK", m_ack, 2'b01);
        chk("zw c2 master_ERR", m_err, 0);
        chk("zw c2 slave_STB", s_stb, 0);
        chk("zw c2 DAT_O m0", m_rdat[31:0], 32'h1234_5678);
        chk("zw c2 DAT_O m1", m_rdat[63:32], 32'h1234_5678);
        m_stb[0] = 1'b0;
        tick();
        chk("zw c3 master_ACK", m_ack, 0);

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            sel = int'(vt[i].addr[31:28]);
            if (sel < NS) begin
                ws[sel] = vt[i].wst;
                stall[sel] = 1'b0;
                s_rdat[sel*32 +: 32] = vt[i].sdat;
            end
            run_txn(vt[i].mst, vt[i].we, vt[i].addr, vt[i].wdat, ga, ge, lat);
            chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d ERR", i), ge, vt[i].exp_err);
            chk($sformatf("vec%0d ACK", i), ga, !vt[i].exp_err);
            chk($sformatf("vec%0d rdata", i), m_rdat[vt[i].mst*DW +: DW], vt[i].exp_rd);
            if (!vt[i].exp_err) begin
                chk($sformatf("vec%0d slave addr", i), acc_addr, vt[i].addr);
                chk($sformatf("vec%0d slave we", i), acc_we, vt[i].we);
                if (vt[i].we) chk($sformatf("vec%0d slave wdat", i), acc_dat, vt[i].wdat);
            end
            tick();
        end

        // Decode error: no slave strobe, ERR in cycle 2 only
        set_req(0, 1'b1, 32'hF000_0000, 32'h7777_7777);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("dec c%0d slave_STB", c), s_stb, 0);
            chk($sformatf("dec c%0d master_ACK", c), m_ack, 0);
            chk($sformatf("dec c%0d master_ERR", c), m_err, (c == 2) ? 2'b01 : 2'b00);
            if (c == 2) m_stb[0] = 1'b0;
        end
        chk("dec rdata", m_rdat[31:0], 0);

        // Both masters hold STB to slave 2; last grant was master 0
        ws[2] = 0;
        s_rdat[2*32 +: 32] = 32'h2222_0000;
        set_req(0, 1'b0, 32'h2000_0000, 32'h0);
        set_req(1, 1'b0, 32'h2000_0000, 32'h0);
        n = 0;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            tick();
            if (m_ack != 0 || m_err != 0) begin
                order[n] = m_ack[1] ? 1 : 0;
                when[n] = c;
                chk("rr single ack", $countones(m_ack) + $countones(m_err) == 1 && m_err == 0, 1);
                n++;
            end
        end
        m_stb = '0;
        chk("rr completions", n, 6);
        prev = 0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("rr grant %0d", k), order[k], (prev + 1) % NM);
            prev = (prev + 1) % NM;
            chk($sformatf("rr cycle %0d", k), when[k], 2 + 3 * k);
        end
        chk("rr rdata", m_rdat[31:0], 32'h2222_0000);
        tick();

        // Abort in cycle 3 of a stalled access
        stall[3] = 1'b1;
        set_req(0, 1'b0, 32'h3000_0000, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("abort c%0d slave_STB", c), s_stb, 5'b01000);
        end
        m_stb[0] = 1'b0;
        any_resp = 1'b0;
        tick();
        chk("abort c4 slave_STB", s_stb, 0);
        for (int c = 0; c < 5; c++) begin
            any_resp = any_resp | (|m_ack) | (|m_err);
            tick();
        end
        chk("abort no response", any_resp, 0);
        chk("abort rdata kept", m_rdat[31:0], 32'h2222_0000);
        stall[3] = 1'b0;
        ws[0] = 0;
        s_rdat[0 +: 32] = 32'h600D_F00D;
        run_txn(0, 1'b0, 32'h0000_0100, 32'h0, ga, ge, lat);
        chk("after abort latency", lat, 2);
        chk("after abort rdata", m_rdat[31:0], 32'h600D_F00D);
        tick();

        // ACK and abort in the same cycle: ACK wins
        ws[3] = 2;
        s_rdat[3*32 +: 32] = 32'h3C3C_3C3C;
        set_req(0, 1'b0, 32'h3000_0000, 32'h0);
        tick(); tick(); tick();
        m_stb[0] = 1'b0;
        tick();
        chk("ack-wins master_ACK", m_ack, 2'b01);
        chk("ack-wins rdata", m_rdat[31:0], 32'h3C3C_3C3C);
        tick();

        // ACKs from unselected slaves are ignored
        stall[3] = 1'b1;
        s_rdat[1*32 +: 32] = 32'hBAD0_0001;
        set_req(0, 1'b0, 32'h3000_0000, 32'h0);
        any_resp = 1'b0;
        tick();
        spur_ack = 5'b10111;
        for (int c = 0; c < 5; c++) begin
            tick();
            any_resp = any_resp | (|m_ack) | (|m_err);
        end
        chk("spurious ack ignored", any_resp, 0);
        chk("spurious STB held", s_stb, 5'b01000);
        spur_ack = '0;
        m_stb[0] = 1'b0;
        tick(); tick();
        chk("spurious rdata kept", m_rdat[31:0], 32'h3C3C_3C3C);
        stall[3] = 1'b0;

        // Randomised traffic from both masters against a transaction model
        for (int j = 0; j < NS; j++) begin
            ws[j] = $urandom_range(0, 3);
            s_rdat[j*32 +: 32] = $urandom;
        end
        exp_rd = 32'h3C3C_3C3C;
        act = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            just = '0;
            chk("rnd STB onehot", $countones(s_stb) <= 1, 1);
            for (int m = 0; m < NM; m++) begin
                if (!act[m]) begin
                    chk($sformatf("rnd idle m%0d resp", m), m_ack[m] | m_err[m], 0);
                end else begin
                    r_wait[m]++;
                    if (m_ack[m] || m_err[m]) begin
                        sel = int'(r_addr[m][31:28]);
                        exp_e = (sel >= NS);
                        chk($sformatf("rnd m%0d ERR", m), m_err[m], exp_e);
                        chk($sformatf("rnd m%0d ACK", m), m_ack[m], !exp_e);
                        if (exp_e) exp_rd = 32'h0;
                        else if (!r_we[m]) exp_rd = s_rdat[sel*32 +: 32];
                        chk($sformatf("rnd m%0d rdata", m), m_rdat[m*DW +: DW], exp_rd);
                        if (!exp_e) begin
                            chk($sformatf("rnd m%0d slave addr", m), acc_addr, r_addr[m]);
                            chk($sformatf("rnd m%0d slave we", m), acc_we, r_we[m]);
                            if (r_we[m]) chk($sformatf("rnd m%0d slave wdat", m), acc_dat, r_wd[m]);
                        end
                        chk($sformatf("rnd m%0d fairness", m), r_oth[m] <= NM - 1, 1);
                        for (int o = 0; o < NM; o++)
                            if (o != m && act[o]) r_oth[o]++;
                        act[m] = 1'b0;
                        just[m] = 1'b1;
                        m_stb[m] = 1'b0;
                    end else if (r_wait[m] > 100) begin
                        chk($sformatf("rnd m%0d response timeout", m), 0, 1);
                        act[m] = 1'b0;
                        m_stb[m] = 1'b0;
                    end
                end
            end
            if (cyc < 2900) begin
                for (int m = 0; m < NM; m++) begin
                    if (!act[m] && !just[m] && ($urandom % 3 == 0)) begin
                        sel = $urandom_range(0, 6);
                        r_addr[m] = {4'(sel), 28'($urandom)};
                        r_we[m] = 1'($urandom);
                        r_wd[m] = $urandom;
                        r_wait[m] = 0;
                        r_oth[m] = 0;
                        act[m] = 1'b1;
                        set_req(m, r_we[m], r_addr[m], r_wd[m]);
                    end
                end
            end else if (act == 0) begin
                break;
            end
        end
        chk("rnd drained", act, 0);
        m_stb = '0;
        tick(); tick();

        // Stalled slave 4: timeout error, or indefinite wait without it
        stall[4] = 1'b1;
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
`ifdef WB_TIMEOUT_EN
        any_resp = 1'b0;
        for (int c = 1; c <= TMO + 1; c++) begin
            tick();
            any_resp = any_resp | (|m_ack) | (|m_err);
        end
        chk("tmo no early response", any_resp, 0);
        chk("tmo STB before expiry", s_stb, 5'b10000);
        tick();
        chk("tmo master_ERR", m_err, 2'b01);
        chk("tmo master_ACK", m_ack, 0);
        chk("tmo rdata", m_rdat[31:0], 0);
        m_stb[0] = 1'b0;
        tick(); tick();
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
        repeat (4) tick();
`else
        any_resp = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            any_resp = any_resp | (|m_ack) | (|m_err);
        end
        chk("stall no response", any_resp, 0);
        chk("stall STB still high", s_stb, 5'b10000);
`endif
        chk("pre-rst slave_ADDR", s_addr, 32'h4000_0000);

        // Asynchronous reset during BUSY
        rstn = 1'b0;
        m_stb = '0;
        #1;
        chk("async rst slave_STB", s_stb, 0);
        chk("async rst master_ACK", m_ack, 0);
        chk("async rst master_ERR", m_err, 0);
        chk("async rst slave_ADDR", s_addr, 0);
        chk("async rst slave_WE", s_we, 0);
        chk("async rst slave_DAT_O", s_wdat, 0);
        chk("async rst master_DAT_O", m_rdat, 0);
        stall[4] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        ws[1] = 0;
        set_req(0, 1'b0, 32'h1000_0000, 32'h0);
        set_req(1, 1'b0, 32'h1000_0000, 32'h0);
        first = -1;
        for (int c = 1; c <= 10 && first < 0; c++) begin
            tick();
            if (m_ack[0]) first = 0;
            else if (m_ack[1]) first = 1;
        end
        m_stb = '0;
        chk("post-rst first grant", first, 0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
